// File: rtl/common_register_bank.sv
// Parametrised register bank: IR, PC and general registers sharing one-hot
// load/drive buses, with a PC return-address stack and sticky error flags.
module common_register_bank #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned REG_NUM     = 6,
    parameter int unsigned EN_WIDTH    = 16,
    parameter int unsigned SKIN_LO     = 11,
    parameter int unsigned SKIN_HI     = 13,
    parameter int unsigned INC_BIT     = 11,
    parameter int unsigned PC_STEP     = 1,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         i_skin_data,
    input  logic [DATA_WIDTH-1:0]         i_core_data,
    input  logic [EN_WIDTH-1:0]           i_unit_ien,
    input  logic [EN_WIDTH-1:0]           i_unit_oen,
    input  logic                          i_call,
    input  logic                          i_ret,
    input  logic                          i_err_clr,
    output logic [DATA_WIDTH-1:0]         o_reg_value,
    output logic [REG_NUM*DATA_WIDTH-1:0] o_reg_flat,
    output logic [DATA_WIDTH-1:0]         o_instruction,
    output logic [DATA_WIDTH-1:0]         o_program_count,
    output logic                          o_stack_full,
    output logic                          o_stack_empty,
    output logic                          o_stack_ovf,
    output logic                          o_stack_unf,
    output logic                          o_multi_drive
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned PC_IX = 1;

    logic [DATA_WIDTH-1:0] regs_q  [REG_NUM];
    logic [DATA_WIDTH-1:0] regs_d  [REG_NUM];
    logic [DATA_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [DATA_WIDTH-1:0] stack_d [STACK_DEPTH];
    logic [SP_W-1:0]       sp_q, sp_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic [DATA_WIDTH-1:0] sc_data;
    logic [DATA_WIDTH-1:0] pc_inc;
    logic [REG_NUM-1:0]    oen_reg;
    logic                  full, empty;
    logic                  call_only, ret_only;
    logic                  call_ok, ret_ok, call_ovf, ret_unf;
    logic [IDX_W-1:0]      push_idx, pop_idx;

    // Source select: skin window wins over core window, otherwise zero
    always_comb begin
        sc_data = '0;
        if (|i_unit_oen[SKIN_HI:SKIN_LO]) begin
            sc_data = i_skin_data;
        end else if (|i_unit_oen[SKIN_LO-1:0]) begin
            sc_data = i_core_data;
        end
    end

    assign full      = (sp_q == SP_W'(STACK_DEPTH));
    assign empty     = (sp_q == '0);
    assign call_only = i_call & ~i_ret;
    assign ret_only  = i_ret & ~i_call;
    assign call_ok   = call_only & ~full;
    assign ret_ok    = ret_only & ~empty;
    assign call_ovf  = call_only & full;
    assign ret_unf   = ret_only & empty;
    assign push_idx  = IDX_W'(sp_q);
    assign pop_idx   = IDX_W'(sp_q - SP_W'(1));
    assign pc_inc    = regs_q[PC_IX] + DATA_WIDTH'(PC_STEP);

    // Next-state for registers, stack, stack pointer and sticky flags
    always_comb begin
        regs_d  = regs_q;
        stack_d = stack_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q & ~i_err_clr;
        unf_d   = unf_q & ~i_err_clr;

        for (int k = 0; k < REG_NUM; k++) begin
            if (k != PC_IX && i_unit_ien[k]) begin
                regs_d[k] = sc_data;
            end
        end

        if (ret_ok) begin
            regs_d[PC_IX] = stack_q[pop_idx];
            sp_d          = sp_q - SP_W'(1);
        end else if (call_ok) begin
            stack_d[push_idx] = pc_inc;
            sp_d              = sp_q + SP_W'(1);
            regs_d[PC_IX]     = sc_data;
        end else if (i_unit_ien[PC_IX] || call_ovf) begin
            regs_d[PC_IX] = sc_data;
        end else if (i_unit_oen[INC_BIT]) begin
            regs_d[PC_IX] = pc_inc;
        end

        if (call_ovf) ovf_d = 1'b1;
        if (ret_unf)  unf_d = 1'b1;
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < REG_NUM; k++)     regs_q[k]  <= '0;
            for (int s = 0; s < STACK_DEPTH; s++) stack_q[s] <= '0;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            stack_q <= stack_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Drive bus: OR of every register whose output enable is set
    always_comb begin
        o_reg_value = '0;
        for (int k = 0; k < REG_NUM; k++) begin
            if (i_unit_oen[k]) o_reg_value = o_reg_value | regs_q[k];
        end
    end

    // Flattened view of all registers
    always_comb begin
        o_reg_flat = '0;
        for (int k = 0; k < REG_NUM; k++) begin
            o_reg_flat[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
        end
    end

    // More than one register drive enable set at once
    assign oen_reg       = i_unit_oen[REG_NUM-1:0];
    assign o_multi_drive = |(oen_reg & (oen_reg - REG_NUM'(1)));

    assign o_instruction   = regs_q[0];
    assign o_program_count = regs_q[PC_IX];
    assign o_stack_full    = full;
    assign o_stack_empty   = empty;
    assign o_stack_ovf     = ovf_q;
    assign o_stack_unf     = unf_q;

endmodule

// File: tb/tb_common_register_bank.sv
// Scoreboard bench for common_register_bank: driver pushes expected outputs
// from a queue-based reference model, monitor pops and compares each cycle.
module tb_common_register_bank;

    localparam int unsigned DW = 16;
    localparam int unsigned RN = 6;
    localparam int unsigned EW = 16;
    localparam int unsigned SD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [DW-1:0] skin, core;
    logic [EW-1:0] ien, oen;
    logic          call, ret, clr;

    logic [DW-1:0]    reg_value, instruction, program_count;
    logic [RN*DW-1:0] reg_flat;
    logic             stack_full, stack_empty, stack_ovf, stack_unf, multi_drive;

    common_register_bank #(
        .DATA_WIDTH(DW), .REG_NUM(RN), .EN_WIDTH(EW), .SKIN_LO(11), .SKIN_HI(13),
        .INC_BIT(11), .PC_STEP(1), .STACK_DEPTH(SD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_skin_data(skin), .i_core_data(core),
        .i_unit_ien(ien), .i_unit_oen(oen),
        .i_call(call), .i_ret(ret), .i_err_clr(clr),
        .o_reg_value(reg_value), .o_reg_flat(reg_flat),
        .o_instruction(instruction), .o_program_count(program_count),
        .o_stack_full(stack_full), .o_stack_empty(stack_empty),
        .o_stack_ovf(stack_ovf), .o_stack_unf(stack_unf),
        .o_multi_drive(multi_drive)
    );

    typedef struct packed {
        logic [DW-1:0]    reg_value;
        logic             multi;
        logic             full;
        logic             empty;
        logic             ovf;
        logic             unf;
        logic [RN*DW-1:0] flat;
        logic [DW-1:0]    ir;
        logic [DW-1:0]    pc;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: plain array of registers and a LIFO queue of return addresses
    logic [DW-1:0] m_regs [RN];
    logic [DW-1:0] m_stack[$];
    logic          m_ovf, m_unf;

    int checks = 0;
    int passed = 0;

    function automatic void model_reset();
        for (int k = 0; k < RN; k++) m_regs[k] = '0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic logic [DW-1:0] model_sc();
        logic [DW-1:0] v;
        v = '0;
        if (oen[11] || oen[12] || oen[13]) v = skin;
        else if (oen[10:0] != 11'd0)       v = core;
        return v;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        int   n;
        e = '0;
        n = 0;
        for (int k = 0; k < RN; k++) begin
            if (oen[k]) begin
                e.reg_value = e.reg_value | m_regs[k];
                n++;
            end
            e.flat[k*DW +: DW] = m_regs[k];
        end
        e.multi = (n > 1);
        e.full  = (m_stack.size() == SD);
        e.empty = (m_stack.size() == 0);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.ir    = m_regs[0];
        e.pc    = m_regs[1];
        return e;
    endfunction

    function automatic void model_edge();
        logic [DW-1:0] sc, pc;
        logic          is_full, is_empty;
        sc       = model_sc();
        pc       = m_regs[1];
        is_full  = (m_stack.size() == SD);
        is_empty = (m_stack.size() == 0);
        for (int k = 0; k < RN; k++) begin
            if (k != 1 && ien[k]) m_regs[k] = sc;
        end
        if (ret && !call && !is_empty) begin
            m_regs[1] = m_stack.pop_back();
        end else if (call && !ret && !is_full) begin
            m_stack.push_back(pc + 16'd1);
            m_regs[1] = sc;
        end else if (ien[1] || (call && !ret && is_full)) begin
            m_regs[1] = sc;
        end else if (oen[11]) begin
            m_regs[1] = pc + 16'd1;
        end
        if (call && !ret && is_full)      m_ovf = 1'b1;
        else if (clr)                     m_ovf = 1'b0;
        if (ret && !call && is_empty)     m_unf = 1'b1;
        else if (clr)                     m_unf = 1'b0;
    endfunction

    function automatic void set_in(input logic [DW-1:0] s, input logic [DW-1:0] c,
                                   input logic [EW-1:0] ie, input logic [EW-1:0] oe,
                                   input logic ca, input logic re, input logic cl);
        skin = s; core = c; ien = ie; oen = oe; call = ca; ret = re; clr = cl;
    endfunction

    // One bus cycle: drive, record expectation for this cycle, advance model at the edge
    task automatic cycle(input logic [DW-1:0] s, input logic [DW-1:0] c,
                         input logic [EW-1:0] ie, input logic [EW-1:0] oe,
                         input logic ca, input logic re, input logic cl);
        @(posedge clk);
        #2;
        set_in(s, c, ie, oe, ca, re, cl);
        exp_q.push_back(expect_now());
        model_edge();
    endtask

    // Reset asserted between edges while a call is pending
    task automatic mid_reset();
        @(posedge clk);
        #2;
        set_in(16'h5555, 16'h0ABC, 16'h0002, 16'h0001, 1'b1, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        model_reset();
        exp_q.push_back(expect_now());
        @(negedge clk);
        #1;
        set_in('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic chk(input string name, input logic [RN*DW-1:0] act, input logic [RN*DW-1:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // Monitor: compare every presented output against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("reg_value",   RN*DW'(reg_value),     RN*DW'(e.reg_value));
                chk("multi_drive", RN*DW'(multi_drive),   RN*DW'(e.multi));
                chk("stack_full",  RN*DW'(stack_full),    RN*DW'(e.full));
                chk("stack_empty", RN*DW'(stack_empty),   RN*DW'(e.empty));
                chk("stack_ovf",   RN*DW'(stack_ovf),     RN*DW'(e.ovf));
                chk("stack_unf",   RN*DW'(stack_unf),     RN*DW'(e.unf));
                chk("reg_flat",    reg_flat,              e.flat);
                chk("instruction", RN*DW'(instruction),   RN*DW'(e.ir));
                chk("program_cnt", RN*DW'(program_count), RN*DW'(e.pc));
            end
        end
    end

    // Driver: directed scenarios followed by random traffic
    initial begin
        logic [EW-1:0] r_oen, r_ien;
        int            drain;
        rst_n = 1'b0;
        set_in('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        model_reset();
        exp_q.push_back(expect_now());
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // PC increments via the INC bit; drive bus stays 0
        repeat (3) cycle('0, '0, '0, 16'h0800, 1'b0, 1'b0, 1'b0);
        // Load reg2 from skin, drive it, load reg3, then double drive
        cycle(16'h1234, 16'h0000, 16'h0004, 16'h1000, 1'b0, 1'b0, 1'b0);
        cycle(16'h0000, 16'h0000, 16'h0000, 16'h0004, 1'b0, 1'b0, 1'b0);
        cycle(16'h0000, 16'h0F0F, 16'h0008, 16'h0001, 1'b0, 1'b0, 1'b0);
        cycle(16'h0000, 16'h0000, 16'h0000, 16'h000C, 1'b0, 1'b0, 1'b0);
        // PC=0x10, call to 0x200, return
        cycle(16'h0000, 16'h0010, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b0);
        cycle(16'h0000, 16'h0200, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0);
        cycle(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        cycle('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        // Five calls against a depth-4 stack, then unwind
        for (int i = 0; i < 5; i++) cycle(16'h0000, 16'h0100 + 16'(i), 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle('0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        cycle('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        // Underflow with increment, clear, then set-wins-over-clear
        cycle('0, '0, '0, 16'h0800, 1'b0, 1'b1, 1'b0);
        cycle('0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle('0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
        cycle('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        // Call and return together: no stack op, no flag
        cycle(16'h0000, 16'h0333, 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b1);
        cycle('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        // PC wrap
        cycle(16'h0000, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b0);
        cycle('0, '0, '0, 16'h0800, 1'b0, 1'b0, 1'b0);
        cycle('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        // Asynchronous reset during a call
        mid_reset();
        cycle('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: r_oen = '0;
                1: r_oen = EW'(1) << $urandom_range(0, EW - 1);
                2: r_oen = (EW'(1) << $urandom_range(0, EW - 1)) | (EW'(1) << $urandom_range(0, EW - 1));
                default: r_oen = EW'($urandom);
            endcase
            r_ien = ($urandom_range(0, 2) == 0) ? EW'($urandom) : '0;
            cycle(DW'($urandom), DW'($urandom), r_ien, r_oen,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0));
            if (n == 200) mid_reset();
        end
        cycle('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
